// File: rtl/key_conditioner.sv
// key_conditioner
// N-channel push-button conditioner: polarity fix, two-flop synchroniser,
// counter debouncer, press/release strobes and optional auto-repeat.
//
// Repeat phase (per channel):
//   state     | meaning
//   ----------+-----------------------------------------------------------
//   PH_IDLE   | no repeat pending (released, or repeat_en low)
//   PH_DELAY  | held with repeat enabled, counting to the first repeat
//   PH_REPEAT | first repeat issued, counting the steady repeat interval

module key_conditioner #(
   parameter int N_KEYS          = 3,
   parameter bit ACTIVE_LOW      = 1'b1,
   parameter int DEBOUNCE_CYCLES = 500000,
   parameter int REPEAT_DELAY    = 25000000,
   parameter int REPEAT_RATE     = 5000000
) (
   input  logic              CLOCK_50,
   input  logic              resetn,
   input  logic [N_KEYS-1:0] key_in,
   input  logic [N_KEYS-1:0] repeat_en,
   output logic [N_KEYS-1:0] key_level,
   output logic [N_KEYS-1:0] key_press,
   output logic [N_KEYS-1:0] key_release
);

   localparam int DW   = $clog2(DEBOUNCE_CYCLES + 1);
   localparam int RMAX = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
   localparam int RW   = $clog2(RMAX + 1);

   // Terminal counts: the counter value seen on the cycle the event fires.
   localparam logic [DW-1:0] DEB_TC  = DW'(DEBOUNCE_CYCLES - 1);
   localparam logic [RW-1:0] DLY_TC  = RW'(REPEAT_DELAY - 1);
   localparam logic [RW-1:0] RATE_TC = RW'(REPEAT_RATE - 1);

   typedef enum logic [1:0] {
      PH_IDLE   = 2'd0,
      PH_DELAY  = 2'd1,
      PH_REPEAT = 2'd2
   } phase_t;

   logic [N_KEYS-1:0] pressed_raw;
   logic [N_KEYS-1:0] sync1_q, sync1_d;
   logic [N_KEYS-1:0] sync2_q, sync2_d;

   // Polarity is normalised before the synchroniser so reset (0) means released.
   assign pressed_raw = key_in ^ {N_KEYS{ACTIVE_LOW}};

   // Synchroniser next-state.
   always_comb begin
      sync1_d = pressed_raw;
      sync2_d = sync1_q;
   end

   // Synchroniser flops.
   always_ff @(posedge CLOCK_50 or negedge resetn) begin
      if (!resetn) begin
         sync1_q <= '0;
         sync2_q <= '0;
      end else begin
         sync1_q <= sync1_d;
         sync2_q <= sync2_d;
      end
   end

   for (genvar i = 0; i < N_KEYS; i++) begin : g_ch
      logic          level_q, level_d;
      logic          press_q, press_d;
      logic          release_q, release_d;
      logic [DW-1:0] deb_cnt_q, deb_cnt_d;
      logic [RW-1:0] rpt_cnt_q, rpt_cnt_d;
      phase_t        phase_q, phase_d;
      logic          rpt_fire;

      // Debounce: count consecutive disagreeing samples, accept on terminal count.
      always_comb begin
         level_d   = level_q;
         deb_cnt_d = deb_cnt_q;
         if (sync2_q[i] == level_q) begin
            deb_cnt_d = '0;
         end else if (deb_cnt_q == DEB_TC) begin
            level_d   = sync2_q[i];
            deb_cnt_d = '0;
         end else begin
            deb_cnt_d = deb_cnt_q + DW'(1);
         end
      end

      // Repeat phase and interval counter; the release cycle forces IDLE so
      // a repeat can never coincide with a release strobe.
      always_comb begin
         phase_d   = phase_q;
         rpt_cnt_d = rpt_cnt_q;
         rpt_fire  = 1'b0;
         if (!level_d || !repeat_en[i]) begin
            phase_d   = PH_IDLE;
            rpt_cnt_d = '0;
         end else begin
            case (phase_q)
               PH_IDLE: begin
                  // Either the accepted press itself or repeat_en rising while held.
                  phase_d   = PH_DELAY;
                  rpt_cnt_d = '0;
               end
               PH_DELAY: begin
                  if (rpt_cnt_q == DLY_TC) begin
                     rpt_fire  = 1'b1;
                     phase_d   = PH_REPEAT;
                     rpt_cnt_d = '0;
                  end else begin
                     rpt_cnt_d = rpt_cnt_q + RW'(1);
                  end
               end
               PH_REPEAT: begin
                  if (rpt_cnt_q == RATE_TC) begin
                     rpt_fire  = 1'b1;
                     rpt_cnt_d = '0;
                  end else begin
                     rpt_cnt_d = rpt_cnt_q + RW'(1);
                  end
               end
               default: begin
                  phase_d   = PH_IDLE;
                  rpt_cnt_d = '0;
               end
            endcase
         end
      end

      // Strobes are registered so they line up with the key_level change.
      always_comb begin
         press_d   = (level_d & ~level_q) | rpt_fire;
         release_d = ~level_d & level_q;
      end

      // Per-channel state flops.
      always_ff @(posedge CLOCK_50 or negedge resetn) begin
         if (!resetn) begin
            level_q   <= 1'b0;
            press_q   <= 1'b0;
            release_q <= 1'b0;
            deb_cnt_q <= '0;
            rpt_cnt_q <= '0;
            phase_q   <= PH_IDLE;
         end else begin
            level_q   <= level_d;
            press_q   <= press_d;
            release_q <= release_d;
            deb_cnt_q <= deb_cnt_d;
            rpt_cnt_q <= rpt_cnt_d;
            phase_q   <= phase_d;
         end
      end

      assign key_level[i]   = level_q;
      assign key_press[i]   = press_q;
      assign key_release[i] = release_q;
   end

endmodule

// File: tb/tb_key_conditioner.sv
// Bench for key_conditioner: window/elapsed-time reference model compared
// every cycle, plus literal cycle-offset expectations per scenario.

module tb_key_conditioner;

   localparam int N  = 3;
   localparam int D  = 4;
   localparam int RD = 10;
   localparam int RR = 3;

   logic         clk;
   logic         resetn;
   logic [N-1:0] key_in;
   logic [N-1:0] repeat_en;
   logic [N-1:0] key_level;
   logic [N-1:0] key_press;
   logic [N-1:0] key_release;

   int checks = 0;
   int errors = 0;
   int cyc    = 0;

   key_conditioner #(
      .N_KEYS          (N),
      .ACTIVE_LOW      (1'b1),
      .DEBOUNCE_CYCLES (D),
      .REPEAT_DELAY    (RD),
      .REPEAT_RATE     (RR)
   ) dut (
      .CLOCK_50    (clk),
      .resetn      (resetn),
      .key_in      (key_in),
      .repeat_en   (repeat_en),
      .key_level   (key_level),
      .key_press   (key_press),
      .key_release (key_release)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Reference model state
   bit           m_pipe1 [N];
   bit           m_pipe2 [N];
   bit           m_win   [N][D];
   bit           m_lvl   [N];
   bit           m_act   [N];
   int           m_start [N];
   logic [N-1:0] e_level, e_press, e_rel;

   // Observed DUT strobes
   int press_cnt [N];
   int rel_cnt   [N];
   int last_press[N];
   int last_rel  [N];
   int q2[$];

   // Model: a level change is accepted when the last D synchronised samples
   // all disagree with the current level; repeats fire at start+RD+k*RR.
   always begin
      bit raw, syn, all_diff, nl;
      int el;
      @(posedge clk);
      cyc++;
      if (!resetn) begin
         for (int c = 0; c < N; c++) begin
            m_pipe1[c] = 1'b0;
            m_pipe2[c] = 1'b0;
            for (int j = 0; j < D; j++) m_win[c][j] = 1'b0;
            m_lvl[c]   = 1'b0;
            m_act[c]   = 1'b0;
            m_start[c] = 0;
         end
         e_level = '0;
         e_press = '0;
         e_rel   = '0;
      end else begin
         for (int c = 0; c < N; c++) begin
            raw        = ~key_in[c];
            syn        = m_pipe2[c];
            m_pipe2[c] = m_pipe1[c];
            m_pipe1[c] = raw;
            for (int j = 0; j < D - 1; j++) m_win[c][j] = m_win[c][j+1];
            m_win[c][D-1] = syn;
            all_diff = 1'b1;
            for (int j = 0; j < D; j++) if (m_win[c][j] == m_lvl[c]) all_diff = 1'b0;
            nl = all_diff ? ~m_lvl[c] : m_lvl[c];
            e_press[c] = nl & ~m_lvl[c];
            e_rel[c]   = ~nl & m_lvl[c];
            if (!nl || !repeat_en[c]) begin
               m_act[c] = 1'b0;
            end else if (!m_act[c]) begin
               m_act[c]   = 1'b1;
               m_start[c] = cyc;
            end else begin
               el = cyc - m_start[c];
               if (el == RD || (el > RD && (el - RD) % RR == 0)) e_press[c] = 1'b1;
            end
            m_lvl[c]   = nl;
            e_level[c] = nl;
         end
      end
      #1;
      checks++;
      if ({key_level, key_press, key_release} !== {e_level, e_press, e_rel}) begin
         errors++;
         $display("FAIL cycle %0d outputs lvl/prs/rel actual %b/%b/%b required %b/%b/%b",
                  cyc, key_level, key_press, key_release, e_level, e_press, e_rel);
      end
      for (int c = 0; c < N; c++) begin
         if (key_press[c] === 1'b1) begin
            press_cnt[c]++;
            last_press[c] = cyc;
            if (c == 2) q2.push_back(cyc);
         end
         if (key_release[c] === 1'b1) begin
            rel_cnt[c]++;
            last_rel[c] = cyc;
         end
      end
   end

   task automatic check_int(input string name, input int act, input int exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual %0d required %0d", name, act, exp);
      end
   endtask

   // Returns at the falling edge following rising edge number t.
   task automatic wait_until(input int t);
      while (cyc < t) @(negedge clk);
   endtask

   int exp_off[8];

   task automatic check_list(input string name, input int p, input int n);
      check_int($sformatf("%s count", name), q2.size(), n);
      for (int i = 0; i < n; i++)
         if (i < q2.size()) check_int($sformatf("%s[%0d]", name, i), q2[i] - p, exp_off[i]);
   endtask

   initial begin
      int a, p, pc, rc;
      for (int c = 0; c < N; c++) begin
         press_cnt[c]  = 0;
         rel_cnt[c]    = 0;
         last_press[c] = -1;
         last_rel[c]   = -1;
      end
      resetn    = 1'b0;
      key_in    = 3'b000;
      repeat_en = 3'b000;

      // Reset with all keys pressed
      repeat (3) @(negedge clk);
      check_int("reset outputs", int'({key_level, key_press, key_release}), 0);
      resetn = 1'b1;
      a = cyc + 1;
      wait_until(a + 4);
      check_int("reset lvl before", int'(key_level), 0);
      wait_until(a + 5);
      check_int("reset lvl at 6", int'(key_level), 7);
      check_int("reset press at 6", int'(key_press), 7);
      wait_until(a + 6);
      check_int("reset press one cycle", int'(key_press), 0);
      check_int("reset lvl held", int'(key_level), 7);
      key_in = 3'b111;
      wait_until(cyc + 12);
      check_int("all released", int'(key_level), 0);

      // Glitch rejection: 3 low samples
      pc = press_cnt[0];
      rc = rel_cnt[0];
      key_in[0] = 1'b0;
      repeat (3) @(negedge clk);
      key_in[0] = 1'b1;
      wait_until(cyc + 12);
      check_int("glitch3 press", press_cnt[0] - pc, 0);
      check_int("glitch3 release", rel_cnt[0] - rc, 0);

      // 4 low samples: accepted
      a = cyc + 1;
      key_in[0] = 1'b0;
      repeat (4) @(negedge clk);
      key_in[0] = 1'b1;
      wait_until(cyc + 15);
      check_int("pulse4 press count", press_cnt[0] - pc, 1);
      check_int("pulse4 press time", last_press[0] - a, 5);
      check_int("pulse4 release time", last_rel[0] - a, 9);

      // Clean press/release on channel 1
      pc = press_cnt[1];
      rc = rel_cnt[1];
      a  = cyc + 1;
      key_in[1] = 1'b0;
      repeat (20) @(negedge clk);
      key_in[1] = 1'b1;
      wait_until(cyc + 15);
      check_int("clean press count", press_cnt[1] - pc, 1);
      check_int("clean release count", rel_cnt[1] - rc, 1);
      check_int("clean press time", last_press[1] - a, 5);
      check_int("clean level width", last_rel[1] - last_press[1], 20);

      // Auto-repeat on channel 2
      repeat_en = 3'b100;
      @(negedge clk);
      q2.delete();
      p = cyc + 6;
      key_in[2] = 1'b0;
      wait_until(p + 24);
      key_in[2] = 1'b1;
      wait_until(p + 40);
      exp_off = '{0, 10, 13, 16, 19, 22, 25, 28};
      check_list("repeat", p, 8);
      check_int("repeat release", last_rel[2] - p, 30);

      // Repeat gating
      q2.delete();
      p = cyc + 6;
      key_in[2] = 1'b0;
      wait_until(p + 11);
      repeat_en[2] = 1'b0;
      wait_until(p + 19);
      repeat_en[2] = 1'b1;
      wait_until(p + 32);
      key_in[2] = 1'b1;
      wait_until(p + 45);
      exp_off = '{0, 10, 30, 33, 36, -1, -1, -1};
      check_list("gating", p, 5);
      check_int("gating release", last_rel[2] - p, 38);

      // Independence: channels 0 and 2 together
      q2.delete();
      pc = press_cnt[0];
      p  = cyc + 6;
      key_in = 3'b010;
      wait_until(p + 11);
      key_in[0] = 1'b1;
      wait_until(p + 20);
      key_in[2] = 1'b1;
      wait_until(p + 35);
      check_int("indep ch0 press time", last_press[0] - p, 0);
      check_int("indep ch0 press count", press_cnt[0] - pc, 1);
      check_int("indep ch0 release", last_rel[0] - p, 17);
      exp_off = '{0, 10, 13, 16, 19, 22, 25, -1};
      check_list("indep ch2", p, 7);
      check_int("indep ch2 release", last_rel[2] - p, 26);

      // Asynchronous reset while held, then fresh press after release of reset
      repeat_en = 3'b000;
      key_in[1] = 1'b0;
      wait_until(cyc + 12);
      check_int("held before reset", int'(key_level), 2);
      resetn = 1'b0;
      #1;
      check_int("async reset clears", int'(key_level), 0);
      repeat (2) @(negedge clk);
      resetn = 1'b1;
      a = cyc + 1;
      wait_until(a + 5);
      check_int("fresh press after reset", int'(key_press), 2);
      key_in = 3'b111;
      wait_until(cyc + 15);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
